logic_serial_engine: RTL and testbench

- Sequencing stage that drives the per-bit reversible logical unit over full-width operands.
- Accepts an operand pair and a 3-bit op code through a valid/ready handshake.
- Evaluates the operation LANES bits per cycle, LSB first, and accumulates the result in a shift register.
- Presents the W-bit result to the ALU result mux or writeback through a second valid/ready handshake.

---
 rtl/logic_serial_engine.sv | 190 +++++++++++++++++++
 tb/tb_logic_serial_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_serial_engine.sv
// logic_serial_engine
// Sequencing stage that runs the per-bit reversible logical unit over a
// full-width operand pair, LANES bits per cycle, LSB first. The result is
// built up in a shift register and handed to the consumer over a
// valid/ready handshake.
//
// Optional feature macro: LOGIC_SERIAL_PARITY_EN
//   When defined, adds the 'parity' output: even parity (XOR reduction) of
//   the result. It is accumulated LANES bits per cycle during RUN.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair and op code are valid
//   in_ready   engine can accept a new operation (IDLE)
//   a, b       W-bit operands
//   op         {s2,s1,s0} logic select
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   out        W-bit result, held until the next result replaces it
//   zero       result is all zeros, qualified by out_valid
//   busy       engine is in RUN
//   parity     (LOGIC_SERIAL_PARITY_EN only) XOR reduction of the result
module logic_serial_engine #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out,
  output logic           zero,
  output logic           busy
`ifdef LOGIC_SERIAL_PARITY_EN
  ,
  output logic           parity
`endif
);

  localparam int STEPS = W / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if ((LANES < 1) || ((W % LANES) != 0)) begin : g_bad_cfg
      $error("logic_serial_engine: W must be a positive multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-bit logical unit applied across all lanes at once.
  function automatic logic [LANES-1:0] lu_lanes(
    input logic [LANES-1:0] x,
    input logic [LANES-1:0] y,
    input logic [2:0]       s
  );
    case (s)
      3'b000:  lu_lanes = x & y;
      3'b001:  lu_lanes = x | y;
      3'b010:  lu_lanes = ~(x & y);
      3'b011:  lu_lanes = ~(x | y);
      3'b100:  lu_lanes = x ^ y;
      3'b101:  lu_lanes = x;
      3'b110:  lu_lanes = ~x;
      3'b111:  lu_lanes = ~(x ^ y);
      default: lu_lanes = {LANES{1'b0}};
    endcase
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [W-1:0]      a_sh_r;
  logic [W-1:0]      b_sh_r;
  logic [2:0]        op_r;
  logic [W-1:0]      res_r;
  logic [W-1:0]      res_nxt_s;
  logic [LANES-1:0]  lane_res_s;
  logic [CW-1:0]     cnt_r;
  logic [W-1:0]      out_r;
  logic              zero_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic              par_r;

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_nxt_s = DONE;
        else               state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Current lane evaluation and the result register with new bits at the MSB end.
  always_comb begin
    lane_res_s = lu_lanes(a_sh_r[LANES-1:0], b_sh_r[LANES-1:0], op_r);
    res_nxt_s  = res_r >> LANES;
    res_nxt_s[W-1 -: LANES] = lane_res_s;
  end

  // Sequencer state, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= {W{1'b0}};
      b_sh_r      <= {W{1'b0}};
      op_r        <= 3'b000;
      res_r       <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_r       <= {W{1'b0}};
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      par_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      // Handshake flags follow the next state so they line up with it.
      in_ready_r  <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s == RUN);
      out_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            op_r   <= op;
            res_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            par_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> LANES;
          b_sh_r <= b_sh_r >> LANES;
          res_r  <= res_nxt_s;
          par_r  <= par_r ^ (^lane_res_s);
          if (cnt_r == LAST) begin
            // Counter wraps only here; the finished word is published.
            cnt_r  <= {CW{1'b0}};
            out_r  <= res_nxt_s;
            zero_r <= ~(|res_nxt_s);
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          // zero is only meaningful while out_valid is high.
          if (out_ready) zero_r <= 1'b0;
        end
        default: begin
          zero_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign zero      = zero_r;
`ifdef LOGIC_SERIAL_PARITY_EN
  assign parity    = par_r;
`endif

endmodule

// File: tb/tb_logic_serial_engine.sv
module tb_logic_serial_engine;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, zero, busy;
  logic [W-1:0]  a = '0, b = '0, out;
  logic [2:0]    op = 3'b000;
`ifdef LOGIC_SERIAL_PARITY_EN
  logic          parity;
  logic          parity4;
`endif

  logic          in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic          in_ready4, out_valid4, zero4, busy4;
  logic [W-1:0]  a4 = '0, b4 = '0, out4;
  logic [2:0]    op4 = 3'b000;

  int checks = 0;
  int failures = 0;

  logic_serial_engine #(.W(W), .LANES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .busy(busy)
`ifdef LOGIC_SERIAL_PARITY_EN
    , .parity(parity)
`endif
  );

  logic_serial_engine #(.W(W), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out(out4), .zero(zero4), .busy(busy4)
`ifdef LOGIC_SERIAL_PARITY_EN
    , .parity(parity4)
`endif
  );

  // Word-level reference: the op table applied to whole operands.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] c);
    case (c)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return ~(x & y);
      3'b011:  return ~(x | y);
      3'b100:  return x ^ y;
      3'b101:  return x;
      3'b110:  return ~x;
      default: return ~(x ^ y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the LANES=1 engine; returns what was observed.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xop,
                       input int hold, output logic [W-1:0] o, output logic z,
                       output logic p, output int lat, output logic ok);
    int guard = 0;
    while (!in_ready && guard < 60) begin step(); guard++; end
    a = xa; b = xb; op = xop; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    ok = out_valid;
    o = out; z = zero;
`ifdef LOGIC_SERIAL_PARITY_EN
    p = parity;
`else
    p = 1'b0;
`endif
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || zero !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b zero=%b out=%h required 1 0 0 0 00000000",
               in_ready, out_valid, busy, zero, out);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    a = 32'hFFFF0000; b = 32'h0F0F0F0F; op = 3'b000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_run_busy: got %b required 1", busy); end
    repeat (10) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_reset: in_ready=%b out_valid=%b busy=%b out=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, out);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_no_valid: out_valid cycles=%0d required 0", seen); end
  endtask

  task automatic test_and_latency();
    logic [W-1:0] o; logic z, p, ok; int lat;
    do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 0, o, z, p, lat, ok);
    checks++;
    if (!ok || lat !== 33) begin failures++; $display("FAIL and_latency: got %0d required 33 (valid=%b)", lat, ok); end
    checks++;
    if (o !== 32'hF000F000 || z !== 1'b0) begin
      failures++; $display("FAIL and_result: got %h zero=%b required f000f000 zero=0", o, z);
    end
`ifdef LOGIC_SERIAL_PARITY_EN
    checks++;
    if (p !== 1'b0) begin failures++; $display("FAIL and_parity: got %b required 0", p); end
`endif
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] exp_tab [8];
    logic [W-1:0] o; logic z, p, ok; int lat;
    exp_tab = '{32'h02040608, 32'h1F3F5F7F, 32'hFDFBF9F7, 32'hE0C0A080,
                32'h1D3B5977, 32'h12345678, 32'hEDCBA987, 32'hE2C4A688};
    for (int k = 0; k < 8; k++) begin
      do_op(32'h12345678, 32'h0F0F0F0F, 3'(k), 0, o, z, p, lat, ok);
      checks++;
      if (!ok || o !== exp_tab[k]) begin
        failures++; $display("FAIL op_sweep_%0d: got %h required %h", k, o, exp_tab[k]);
      end
    end
  endtask

  task automatic test_zero_flag();
    logic [W-1:0] o; logic z, p, ok; int lat;
    do_op(32'hAAAAAAAA, 32'hAAAAAAAA, 3'b100, 0, o, z, p, lat, ok);
    checks++;
    if (!ok || o !== 32'h0 || z !== 1'b1) begin
      failures++; $display("FAIL zero_flag: got %h zero=%b required 00000000 zero=1", o, z);
    end
    checks++;
    if (zero !== 1'b0 || out !== 32'h0) begin
      failures++; $display("FAIL zero_after_done: zero=%b out=%h required 0 00000000", zero, out);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp1, exp2, na;
    int guard = 0;
    int bad = 0;
    exp1 = ref_op(32'h11111111, 32'h0000FFFF, 3'b100);
    a = 32'h11111111; b = 32'h0000FFFF; op = 3'b100; in_valid = 1'b1; out_ready = 1'b0;
    step();
    while (!out_valid && guard < 100) begin a = $urandom; step(); guard++; end
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      step();
      if (out_valid !== 1'b1 || out !== exp1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL backpressure_hold: bad cycles=%0d out=%h required %h", bad, out, exp1);
    end
    na = $urandom;
    a = na; b = 32'hCAFEF00D; op = 3'b001;
    exp2 = ref_op(na, 32'hCAFEF00D, 3'b001);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== exp1) begin
      failures++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b out=%h required 1 0 %h",
                           in_ready, out_valid, out, exp1);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL backpressure_next_accept: busy=%b required 1", busy); end
    guard = 0;
    while (!out_valid && guard < 100) begin step(); guard++; end
    checks++;
    if (out_valid !== 1'b1 || out !== exp2) begin
      failures++; $display("FAIL backpressure_next_result: got %h required %h", out, exp2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] o, xa, xb, e; logic [2:0] xo; logic z, p, ok; int lat;
    for (int n = 0; n < 24; n++) begin
      xa = $urandom; xb = $urandom; xo = 3'($urandom);
      if (n == 5) xb = xa;
      e = ref_op(xa, xb, xo);
      do_op(xa, xb, xo, $urandom_range(0, 3), o, z, p, lat, ok);
      checks++;
      if (!ok || o !== e || z !== (e == '0) || lat !== 33) begin
        failures++;
        $display("FAIL random_%0d: op=%b out=%h zero=%b lat=%0d required %h %b 33", n, xo, o, z, lat, e, (e == '0));
      end
      checks++;
      if (out !== e || out_valid !== 1'b0) begin
        failures++; $display("FAIL random_hold_%0d: out=%h out_valid=%b required %h 0", n, out, out_valid, e);
      end
`ifdef LOGIC_SERIAL_PARITY_EN
      checks++;
      if (p !== ^e) begin failures++; $display("FAIL random_parity_%0d: got %b required %b", n, p, ^e); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q [$];
    logic [W-1:0] e;
    int last_valid = -1;
    int results = 0;
    int bad_inv = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      if ((in_ready && busy) || (in_ready && out_valid)) bad_inv++;
      if (out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        checks++;
        if (out !== e) begin failures++; $display("FAIL b2b_result: got %h required %h", out, e); end
        if (last_valid >= 0) begin
          checks++;
          if (c - last_valid !== 34) begin
            failures++; $display("FAIL b2b_spacing: got %0d required 34", c - last_valid);
          end
        end
        last_valid = c;
        results++;
      end
      a = $urandom; b = $urandom; op = 3'($urandom);
      if (in_ready) q.push_back(ref_op(a, b, op));
      step();
    end
    in_valid = 1'b0;
    repeat (40) step();
    out_ready = 1'b0;
    checks++;
    if (results !== 3 || bad_inv !== 0) begin
      failures++; $display("FAIL b2b_count: results=%0d invariant_violations=%0d required 3 0", results, bad_inv);
    end
  endtask

  task automatic test_lanes4();
    logic [W-1:0] xa, xb, e; logic [2:0] xo;
    int lat;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin xa = 32'hFFFFFFFF; xb = 32'h0; xo = 3'b110; end
      else begin xa = $urandom; xb = $urandom; xo = 3'($urandom); end
      e = ref_op(xa, xb, xo);
      a4 = xa; b4 = xb; op4 = xo; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 100) begin step(); lat++; end
      checks++;
      if (!out_valid4 || lat !== 9 || out4 !== e || zero4 !== (e == '0)) begin
        failures++;
        $display("FAIL lanes4_%0d: out=%h zero=%b lat=%0d required %h %b 9", n, out4, zero4, lat, e, (e == '0));
      end
`ifdef LOGIC_SERIAL_PARITY_EN
      checks++;
      if (parity4 !== ^e) begin failures++; $display("FAIL lanes4_parity_%0d: got %b required %b", n, parity4, ^e); end
`endif
      out_ready4 = 1'b1;
      step();
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_and_latency();
    test_op_sweep();
    test_zero_flag();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_lanes4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
